bp_output_error_sequencer: RTL and testbench
============================================

Name: bp_output_error_sequencer

Overview:
Sequences output-layer back-propagation error computation for the DQN training path. For NUM_NODES output nodes: reads node output and expected value from a dual-read buffer, streams pairs into the shared pipelined FP32 subtractor (error = node − expected), and writes returned errors into an error buffer indexed by node. Triggered once per training step by the training controller; signals completion to the hidden-layer back-propagation stage.

Parameters:
DATA_WIDTH, 32, FP32 word width
NUM_NODES, 4, output nodes (Q-values/actions) per step; ≥1
ADDR_WIDTH, 2, buffer address width; ≥ clog2(NUM_NODES), min 1
SUB_LATENCY, 7, subtractor valid-in to valid-out latency in clocks

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled in IDLE only
o_busy  out  1  high from first ISSUE cycle through DONE
o_done  out  1  one-cycle completion pulse
o_rd_en  out  1  buffer read strobe; data returns next cycle
o_rd_addr  out  ADDR_WIDTH  node index being read
i_rd_data_node  in  DATA_WIDTH  node output value (1-cycle read latency)
i_rd_data_expected  in  DATA_WIDTH  target value (1-cycle read latency)
o_sub_valid  out  1  subtractor valid_in
o_sub_data_node  out  DATA_WIDTH  subtractor operand A
o_sub_data_expected  out  DATA_WIDTH  subtractor operand B; subtractor negates internally
i_sub_valid  in  1  subtractor valid_out
i_sub_data  in  DATA_WIDTH  subtractor result
o_wr_en  out  1  error buffer write strobe
o_wr_addr  out  ADDR_WIDTH  error buffer address
o_wr_data  out  DATA_WIDTH  error value

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; o_busy, o_done, o_rd_en, o_sub_valid, o_wr_en = 0; address and data outputs = 0.
- FSM: IDLE -> ISSUE on i_start. ISSUE -> DRAIN after issuing index NUM_NODES-1. DRAIN -> DONE on the cycle the NUM_NODES-th write is registered. DONE -> IDLE unconditionally after one cycle.
- ISSUE: o_rd_en=1, o_rd_addr=issue_cnt; issue_cnt increments each cycle, one read per cycle, no bubbles.
- o_sub_valid = o_rd_en delayed one register. o_sub_data_* = i_rd_data_* passed combinationally; valid in same cycle as o_sub_valid.
- Results return in order, so no tags: wr_cnt counts accepted i_sub_valid. On i_sub_valid in ISSUE/DRAIN with wr_cnt<NUM_NODES, register o_wr_en=1, o_wr_addr=wr_cnt, o_wr_data=i_sub_data the next cycle; wr_cnt++.
- Timing, start at cycle 0: rd_en cycles 1..N; sub_valid 2..N+1; results 2+SUB_LATENCY..; writes one cycle after each result; o_done on the cycle after the last write, then IDLE. For N=4, L=7: writes 10..13, done 14. o_busy is high cycles 1..14.
- o_busy = (state != IDLE). o_done = (state == DONE).
- Boundaries:
  - i_start outside IDLE is ignored, including during DONE.
  - i_sub_valid in IDLE or DONE, or with wr_cnt==NUM_NODES, is dropped with no write.
  - NUM_NODES=1: ISSUE lasts one cycle.
  - Reset mid-operation aborts immediately, with no partial done.
  - Counters never wrap within a step.

Optional Feature:
BP_SEQ_WATCHDOG_EN: adds output o_timeout (1 bit, reset 0) and a DRAIN-idle counter, cleared on each i_sub_valid. If the counter reaches SUB_LATENCY+4 in DRAIN, the block pulses o_timeout for one cycle, goes to IDLE without o_done, and drops remaining results. Without the macro: no port, no counter, and DRAIN waits indefinitely.

Decomposition:
- Shared package: FSM state encoding (IDLE, ISSUE, DRAIN, DONE; 2-bit) and the default SUB_LATENCY constant, reused by the hidden-layer sequencer.
- No sub-module required. The subtractor stays external so it can be shared with other layer sequencers.

Test Plan:
- N=4, node={1.0,2.0,3.0,4.0} (0x3F800000,0x40000000,0x40400000,0x40800000), expected=0.5 each; 7-cycle subtractor model -> writes addr0..3 = 0x3F000000,0x3FC00000,0x40200000,0x40600000 at cycles 10..13; o_done at 14; o_busy cycles 1..14.
- i_start pulsed at cycles 3 and 14 of a running step -> both ignored; exactly 4 writes and one o_done.
- Spurious i_sub_valid in IDLE and a fifth result after 4 writes -> no o_wr_en.
- rst_n low at cycle 11 -> all outputs 0 asynchronously; no o_done. A fresh start then completes normally.
- NUM_NODES=1: node=1.0, expected=1.0 -> one write, addr0 = 0x00000000; o_done at cycle 11.
- With BP_SEQ_WATCHDOG_EN, subtractor withholds the last result -> o_timeout pulse 11 cycles after the last result; no o_done; IDLE afterwards.

Source files
------------

// File: rtl/bp_output_error_sequencer_pkg.sv
// Shared definitions for the back-propagation layer sequencers:
// FSM state encoding and the default subtractor latency.
package bp_output_error_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bp_seq_state_e;

  localparam int BP_SEQ_SUB_LATENCY = 7;

endpackage

// File: rtl/bp_output_error_sequencer.sv
// Output-layer error sequencer: reads node/expected pairs, feeds the shared FP32
// subtractor and writes in-order results to the error buffer. Optional DRAIN watchdog: BP_SEQ_WATCHDOG_EN.
module bp_output_error_sequencer
  import bp_output_error_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_NODES   = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int SUB_LATENCY = BP_SEQ_SUB_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data_node,
  input  logic [DATA_WIDTH-1:0] i_rd_data_expected,
  output logic                  o_sub_valid,
  output logic [DATA_WIDTH-1:0] o_sub_data_node,
  output logic [DATA_WIDTH-1:0] o_sub_data_expected,
  input  logic                  i_sub_valid,
  input  logic [DATA_WIDTH-1:0] i_sub_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data
`ifdef BP_SEQ_WATCHDOG_EN
  ,
  output logic                  o_timeout
`endif
);

  // Write counter must be able to hold NUM_NODES itself to mark "all results in".
  localparam int CNT_W = $clog2(NUM_NODES + 1);
  localparam logic [CNT_W-1:0]      WR_ALL     = CNT_W'(NUM_NODES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ISSUE = ADDR_WIDTH'(NUM_NODES - 1);

  bp_seq_state_e          state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]       wr_cnt_reg;
  logic                   sub_valid_reg;
  logic                   wr_en_reg;
  logic [ADDR_WIDTH-1:0]  wr_addr_reg;
  logic [DATA_WIDTH-1:0]  wr_data_reg;
  logic                   sub_accept;
  logic                   timeout_hit;

  assign sub_accept = i_sub_valid
                    && (state_reg == ST_ISSUE || state_reg == ST_DRAIN)
                    && (wr_cnt_reg < WR_ALL);

`ifdef BP_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(SUB_LATENCY + 5) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(SUB_LATENCY + 4);

  logic [WD_W-1:0] idle_cnt_reg;

  // idle_cnt_reg + 1 is the number of result-free DRAIN cycles including this one.
  assign timeout_hit = (state_reg == ST_DRAIN) && !i_sub_valid
                     && (wr_cnt_reg != WR_ALL)
                     && (idle_cnt_reg + WD_W'(1) == WD_LIMIT);
  assign o_timeout   = timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (i_sub_valid || state_reg != ST_DRAIN) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_start) state_next = ST_ISSUE;
      ST_ISSUE: if (issue_cnt_reg == LAST_ISSUE) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (wr_cnt_reg == WR_ALL) begin
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      issue_cnt_reg <= '0;
      wr_cnt_reg    <= '0;
      sub_valid_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= (state_reg == ST_ISSUE && state_next == ST_ISSUE)
                       ? issue_cnt_reg + ADDR_WIDTH'(1) : '0;
      sub_valid_reg <= (state_reg == ST_ISSUE);
      wr_en_reg     <= sub_accept;
      // Results come back in issue order, so the write count is the node index.
      if (state_reg == ST_IDLE) begin
        wr_cnt_reg <= '0;
      end else if (sub_accept) begin
        wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
      end
      if (sub_accept) begin
        wr_addr_reg <= ADDR_WIDTH'(wr_cnt_reg);
        wr_data_reg <= i_sub_data;
      end
    end
  end

  assign o_busy              = (state_reg != ST_IDLE);
  assign o_done              = (state_reg == ST_DONE);
  assign o_rd_en             = (state_reg == ST_ISSUE);
  assign o_rd_addr           = o_rd_en ? issue_cnt_reg : '0;
  assign o_sub_valid         = sub_valid_reg;
  // Operands are masked so they read zero whenever they are not being presented.
  assign o_sub_data_node     = sub_valid_reg ? i_rd_data_node     : '0;
  assign o_sub_data_expected = sub_valid_reg ? i_rd_data_expected : '0;
  assign o_wr_en             = wr_en_reg;
  assign o_wr_addr           = wr_addr_reg;
  assign o_wr_data           = wr_data_reg;

endmodule

// File: tb/tb_bp_output_error_sequencer.sv
// Bench for bp_output_error_sequencer: buffer and 7-stage subtractor models, table vectors,
// random steps against a reference model, and multi-cycle corner sequences.
module tb_bp_output_error_sequencer;
  import bp_output_error_sequencer_pkg::*;

  localparam int N        = 4;
  localparam int L        = BP_SEQ_SUB_LATENCY;
  localparam int FIRST_WR = L + 3;
  localparam int DONE_REL = N + L + 3;

  typedef logic [N-1:0][31:0] word_vec_t;
  typedef struct packed { word_vec_t node; word_vec_t expv; word_vec_t err; } vec_t;
  typedef struct { int rel; logic [1:0] addr; logic [31:0] data; } wr_ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  int rel;
  int drop_rel = -1000000;
  always @(posedge clk) cyc <= cyc + 1;
  assign rel = cyc - start_cyc;

  // ---------------- DUT (N=4) ----------------
  logic        i_start = 1'b0, o_busy, o_done, o_rd_en, o_sub_valid, i_sub_valid, o_wr_en;
  logic [1:0]  o_rd_addr, o_wr_addr;
  logic [31:0] rd_node, rd_exp, o_sub_data_node, o_sub_data_expected, i_sub_data, o_wr_data;
  logic        inj_v = 1'b0;
  logic [31:0] inj_d = '0;
`ifdef BP_SEQ_WATCHDOG_EN
  logic        o_timeout;
`endif

  bp_output_error_sequencer #(.DATA_WIDTH(32), .NUM_NODES(N), .ADDR_WIDTH(2), .SUB_LATENCY(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data_node(rd_node), .i_rd_data_expected(rd_exp),
    .o_sub_valid(o_sub_valid), .o_sub_data_node(o_sub_data_node),
    .o_sub_data_expected(o_sub_data_expected),
    .i_sub_valid(i_sub_valid), .i_sub_data(i_sub_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
`ifdef BP_SEQ_WATCHDOG_EN
    , .o_timeout(o_timeout)
`endif
  );

  // ---------------- DUT (N=1) ----------------
  logic        i_start_1 = 1'b0, o_busy_1, o_done_1, o_rd_en_1, o_sub_valid_1, o_wr_en_1;
  logic [0:0]  o_rd_addr_1, o_wr_addr_1;
  logic [31:0] rd_node_1, rd_exp_1, o_sub_data_node_1, o_sub_data_expected_1, o_wr_data_1;
  logic [31:0] node_1 = '0, exp_1 = '0;
`ifdef BP_SEQ_WATCHDOG_EN
  logic        o_timeout_1;
`endif

  // ---------------- environment models ----------------
  function automatic real fp2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return r2fp(fp2r(a) - fp2r(b));
  endfunction

  function automatic word_vec_t pack4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  word_vec_t node_mem, exp_mem;
  always @(posedge clk) if (o_rd_en) begin
    rd_node <= node_mem[o_rd_addr];
    rd_exp  <= exp_mem[o_rd_addr];
  end
  always @(posedge clk) if (o_rd_en_1) begin
    rd_node_1 <= node_1;
    rd_exp_1  <= exp_1;
  end

  logic        pv [L];
  logic [31:0] pd [L];
  logic        pv1 [L];
  logic [31:0] pd1 [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin pv[k] <= 1'b0; pv1[k] <= 1'b0; end
    end else begin
      pv[0]  <= o_sub_valid;   pd[0]  <= fp_sub(o_sub_data_node, o_sub_data_expected);
      pv1[0] <= o_sub_valid_1; pd1[0] <= fp_sub(o_sub_data_node_1, o_sub_data_expected_1);
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];   pd[k] <= pd[k-1];
        pv1[k] <= pv1[k-1]; pd1[k] <= pd1[k-1];
      end
    end
  end
  assign i_sub_valid = (pv[L-1] && rel != drop_rel) || inj_v;
  assign i_sub_data  = inj_v ? inj_d : pd[L-1];

  bp_output_error_sequencer #(.DATA_WIDTH(32), .NUM_NODES(1), .ADDR_WIDTH(1), .SUB_LATENCY(L)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_1), .o_busy(o_busy_1), .o_done(o_done_1),
    .o_rd_en(o_rd_en_1), .o_rd_addr(o_rd_addr_1),
    .i_rd_data_node(rd_node_1), .i_rd_data_expected(rd_exp_1),
    .o_sub_valid(o_sub_valid_1), .o_sub_data_node(o_sub_data_node_1),
    .o_sub_data_expected(o_sub_data_expected_1),
    .i_sub_valid(pv1[L-1]), .i_sub_data(pd1[L-1]),
    .o_wr_en(o_wr_en_1), .o_wr_addr(o_wr_addr_1), .o_wr_data(o_wr_data_1)
`ifdef BP_SEQ_WATCHDOG_EN
    , .o_timeout(o_timeout_1)
`endif
  );

  // ---------------- monitor (samples on falling edge) ----------------
  wr_ev_t wq[$];
  wr_ev_t wq1[$];
  int done_q[$];
  int done_q1[$];
  int to_q[$];
  int busy_cnt = 0, busy_first = -1, busy_last = -1;

  always @(negedge clk) begin
    if (o_wr_en)   wq.push_back('{rel, o_wr_addr, o_wr_data});
    if (o_wr_en_1) wq1.push_back('{rel, {1'b0, o_wr_addr_1}, o_wr_data_1});
    if (o_done)    done_q.push_back(rel);
    if (o_done_1)  done_q1.push_back(rel);
    if (o_busy) begin
      if (busy_cnt == 0) busy_first = rel;
      busy_last = rel;
      busy_cnt++;
    end
`ifdef BP_SEQ_WATCHDOG_EN
    if (o_timeout) to_q.push_back(rel);
`endif
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int x);
    while (rel < x) tick(1);
  endtask

  task automatic clear_logs();
    wq.delete(); wq1.delete(); done_q.delete(); done_q1.delete(); to_q.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1;
  endtask

  task automatic start_step(input word_vec_t n, input word_vec_t e);
    node_mem = n; exp_mem = e;
    clear_logs();
    start_cyc = cyc;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  // Reference: node i produces one write of err[i] at address i, L+3+i cycles after start.
  task automatic check_step(input string tag, input word_vec_t err);
    chk($sformatf("%s writes", tag), 32'(wq.size()), 32'(N));
    for (int i = 0; i < N && i < wq.size(); i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), 32'(wq[i].addr), 32'(i));
      chk($sformatf("%s wr%0d data", tag, i), wq[i].data, err[i]);
      chk($sformatf("%s wr%0d cycle", tag, i), 32'(wq[i].rel), 32'(FIRST_WR + i));
    end
    chk($sformatf("%s dones", tag), 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk($sformatf("%s done cycle", tag), 32'(done_q[0]), 32'(DONE_REL));
    chk($sformatf("%s busy first", tag), 32'(busy_first), 32'd1);
    chk($sformatf("%s busy last", tag), 32'(busy_last), 32'(DONE_REL));
    chk($sformatf("%s busy cycles", tag), 32'(busy_cnt), 32'(DONE_REL));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"},   32'(o_busy), 32'd0);
    chk({tag, " done"},   32'(o_done), 32'd0);
    chk({tag, " rd_en"},  32'(o_rd_en), 32'd0);
    chk({tag, " rd_addr"}, 32'(o_rd_addr), 32'd0);
    chk({tag, " sub_v"},  32'(o_sub_valid), 32'd0);
    chk({tag, " sub_a"},  o_sub_data_node, 32'd0);
    chk({tag, " sub_b"},  o_sub_data_expected, 32'd0);
    chk({tag, " wr_en"},  32'(o_wr_en), 32'd0);
    chk({tag, " wr_addr"}, 32'(o_wr_addr), 32'd0);
    chk({tag, " wr_data"}, o_wr_data, 32'd0);
  endtask

  vec_t tbl [3];

  initial begin
    tbl[0].node = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    tbl[0].expv = pack4(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    tbl[0].err  = pack4(32'h3F000000, 32'h3FC00000, 32'h40200000, 32'h40600000);
    tbl[1].node = pack4(32'h40000000, 32'h00000000, 32'hBF800000, 32'h41000000);
    tbl[1].expv = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tbl[1].err  = pack4(32'h3F800000, 32'hBF800000, 32'hC0000000, 32'h40E00000);
    tbl[2].node = pack4(32'h3F000000, 32'h3F000000, 32'h41200000, 32'hC0400000);
    tbl[2].expv = pack4(32'h3F000000, 32'h3FC00000, 32'h40000000, 32'hC0400000);
    tbl[2].err  = pack4(32'h00000000, 32'hBF800000, 32'h41000000, 32'h00000000);

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Table vectors
    for (int t = 0; t < 3; t++) begin
      start_step(tbl[t].node, tbl[t].expv);
      wait_rel(DONE_REL + 6);
      check_step($sformatf("tbl%0d", t), tbl[t].err);
    end

    // Randomized steps against the integer-arithmetic reference
    for (int r = 0; r < 6; r++) begin
      word_vec_t n, e, w;
      for (int i = 0; i < N; i++) begin
        int a, b;
        a = int'($urandom_range(0, 128)) - 64;
        b = int'($urandom_range(0, 128)) - 64;
        n[i] = r2fp(real'(a));
        e[i] = r2fp(real'(b));
        w[i] = r2fp(real'(a - b));
      end
      tick(int'($urandom_range(0, 3)));
      start_step(n, e);
      wait_rel(DONE_REL + 6);
      check_step($sformatf("rnd%0d", r), w);
    end

    // i_start during ISSUE and during DONE is ignored
    start_step(tbl[0].node, tbl[0].expv);
    wait_rel(3);  i_start = 1'b1; tick(1); i_start = 1'b0;
    wait_rel(14); i_start = 1'b1; tick(1); i_start = 1'b0;
    wait_rel(DONE_REL + 8);
    check_step("restart", tbl[0].err);

    // Spurious result in IDLE
    clear_logs();
    inj_v = 1'b1; inj_d = 32'hDEADBEEF; tick(2); inj_v = 1'b0;
    tick(3);
    chk("idle spurious writes", 32'(wq.size()), 32'd0);

    // Fifth result after all four writes, and one during DONE
    start_step(tbl[1].node, tbl[1].expv);
    wait_rel(13); inj_v = 1'b1; inj_d = 32'hCAFEF00D; tick(2); inj_v = 1'b0;
    wait_rel(DONE_REL + 6);
    check_step("extra", tbl[1].err);

    // Asynchronous reset mid-step
    start_step(tbl[0].node, tbl[0].expv);
    wait_rel(11);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("midrst dones", 32'(done_q.size()), 32'd0);
    start_step(tbl[2].node, tbl[2].expv);
    wait_rel(DONE_REL + 6);
    check_step("after_rst", tbl[2].err);

    // NUM_NODES=1: 1.0 - 1.0
    node_1 = 32'h3F800000; exp_1 = 32'h3F800000;
    clear_logs();
    start_cyc = cyc;
    i_start_1 = 1'b1; tick(1); i_start_1 = 1'b0;
    wait_rel(20);
    chk("n1 writes", 32'(wq1.size()), 32'd1);
    if (wq1.size() > 0) begin
      chk("n1 addr", 32'(wq1[0].addr), 32'd0);
      chk("n1 data", wq1[0].data, 32'h00000000);
      chk("n1 cycle", 32'(wq1[0].rel), 32'(L + 3));
    end
    chk("n1 dones", 32'(done_q1.size()), 32'd1);
    if (done_q1.size() > 0) chk("n1 done cycle", 32'(done_q1[0]), 32'(L + 4));

`ifdef BP_SEQ_WATCHDOG_EN
    // Last result withheld: timeout 11 idle cycles after the result at L+4
    drop_rel = L + 5;
    start_step(tbl[0].node, tbl[0].expv);
    wait_rel(40);
    drop_rel = -1000000;
    chk("wd writes", 32'(wq.size()), 32'(N - 1));
    chk("wd dones", 32'(done_q.size()), 32'd0);
    chk("wd timeouts", 32'(to_q.size()), 32'd1);
    if (to_q.size() > 0) chk("wd timeout cycle", 32'(to_q[0]), 32'(L + 4 + L + 4));
    chk("wd busy last", 32'(busy_last), 32'(L + 4 + L + 4));
    chk("wd idle after", 32'(o_busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
